// File: rtl/line_buffer_taps.sv
// Multi-line pixel buffer: emits a vertical column of NUM_LINES+1 taps per accepted pixel,
// with frame/line framing, fill masking of unwritten lines and a sticky short-line flag.

module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module line_buffer_taps #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_BITS  = 10,
    parameter int NUM_LINES  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic                                  in_sof,
    input  logic                                  in_sol,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    output logic [(NUM_LINES+1)*DATA_WIDTH-1:0]   out_taps,
    output logic [ADDR_BITS-1:0]                  out_col,
    output logic                                  out_full,
    output logic                                  err_short_line
);
    localparam int                   FW       = $clog2(NUM_LINES + 1);
    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(LINE_WIDTH - 1);
    localparam logic [FW-1:0]        FILL_MAX = FW'(NUM_LINES);

    typedef struct packed {
        logic [ADDR_BITS-1:0] col;       // column of the incoming pixel
        logic [FW-1:0]        fill;      // lines visible to this pixel's taps
        logic [ADDR_BITS-1:0] col_nxt;
        logic [FW-1:0]        fill_nxt;
        logic                 err_nxt;
    } pix_ctl_t;

    function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] f);
        return (f == FILL_MAX) ? f : f + FW'(1);
    endfunction

    logic [ADDR_BITS-1:0] col_q;
    logic [FW-1:0]        fill_q;
    pix_ctl_t             ctl;
    logic [NUM_LINES-1:0] tap_en_nxt, tap_en_q;

    logic                                  vld_q, hit_q, rd_en;
    logic [DATA_WIDTH-1:0]                 pix_q;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0]  rd, fwd_q, old, wdata;

    // Framing: sof restarts the frame; sol off column 0 closes a short line early.
    always_comb begin
        ctl         = '0;
        ctl.col     = col_q;
        ctl.fill    = fill_q;
        ctl.err_nxt = err_short_line;
        if (in_sof) begin
            ctl.col     = '0;
            ctl.fill    = '0;
            ctl.err_nxt = 1'b0;
        end else if (in_sol) begin
            ctl.col = '0;
            if (col_q != '0) begin
                ctl.err_nxt = 1'b1;
                ctl.fill    = fill_inc(fill_q);
            end
        end
        if (ctl.col == LAST_COL) begin
            ctl.col_nxt  = '0;
            ctl.fill_nxt = fill_inc(ctl.fill);
        end else begin
            ctl.col_nxt  = ctl.col + ADDR_BITS'(1);
            ctl.fill_nxt = ctl.fill;
        end
    end

    always_comb begin
        tap_en_nxt = '0;
        for (int k = 0; k < NUM_LINES; k++)
            tap_en_nxt[k] = (int'(ctl.fill) > k);
    end

    // RAM writes lag the read by one cycle; a back-to-back pixel on the same column
    // takes the in-flight write data instead of the stale RAM word.
    always_comb begin
        old   = '0;
        wdata = '0;
        for (int k = 0; k < NUM_LINES; k++)
            old[k] = hit_q ? fwd_q[k] : rd[k];
        wdata[0] = pix_q;
        for (int k = 1; k < NUM_LINES; k++)
            wdata[k] = old[k-1];
    end

    assign rd_en = in_valid & ~rst;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        line_buffer_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH),
            .ADDR_BITS  (ADDR_BITS)
        ) u_ram (
            .clk   (clk),
            .we    (vld_q),
            .waddr (out_col),
            .wdata (wdata[g]),
            .re    (rd_en),
            .raddr (ctl.col),
            .rdata (rd[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            fill_q         <= '0;
            err_short_line <= 1'b0;
            out_full       <= 1'b0;
            vld_q          <= 1'b0;
            out_col        <= '0;
            pix_q          <= '0;
            tap_en_q       <= '0;
            hit_q          <= 1'b0;
            fwd_q          <= '0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                col_q          <= ctl.col_nxt;
                fill_q         <= ctl.fill_nxt;
                err_short_line <= ctl.err_nxt;
                out_full       <= (ctl.fill_nxt == FILL_MAX);
                out_col        <= ctl.col;
                pix_q          <= in_data;
                tap_en_q       <= tap_en_nxt;
                hit_q          <= vld_q && (out_col == ctl.col);
                fwd_q          <= wdata;
            end
        end
    end

    assign out_valid = vld_q;

    always_comb begin
        out_taps                 = '0;
        out_taps[0 +: DATA_WIDTH] = pix_q;
        for (int k = 0; k < NUM_LINES; k++)
            if (tap_en_q[k]) out_taps[(k+1)*DATA_WIDTH +: DATA_WIDTH] = old[k];
    end
endmodule

// File: tb/tb_line_buffer_taps.sv
// Bench for line_buffer_taps: directed vector table, hand sequences for framing corners,
// and random traffic against a line-history model.

module tb_line_buffer_taps;
    localparam int DW = 8, LW = 4, AB = 2, NL = 2, TW = (NL+1)*DW;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_sof, in_sol;
    logic [DW-1:0] in_data;
    logic          out_valid, out_full, err_short_line;
    logic [TW-1:0] out_taps;
    logic [AB-1:0] out_col;

    int total = 0, bad = 0;

    line_buffer_taps #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_BITS(AB), .NUM_LINES(NL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_sol(in_sol),
        .in_data(in_data), .out_valid(out_valid), .out_taps(out_taps), .out_col(out_col),
        .out_full(out_full), .err_short_line(err_short_line));

    always #5 clk = ~clk;

    // Model: hist[k-1][c] is the pixel at column c, k lines above the next one.
    logic [DW-1:0] hist [NL][LW];
    int            m_col, m_fill;
    logic          m_err, m_full, m_valid;
    logic [TW-1:0] m_taps;
    logic [AB-1:0] m_colout;

    task automatic model_step(input logic r, v, s, l, input logic [DW-1:0] d);
        int c, f;
        if (r) begin
            m_col = 0; m_fill = 0; m_err = 0; m_full = 0;
            m_valid = 0; m_taps = '0; m_colout = '0;
        end else if (v) begin
            c = m_col; f = m_fill;
            if (s) begin
                c = 0; f = 0; m_err = 0;
            end else if (l) begin
                if (m_col != 0) begin m_err = 1; f = (f < NL) ? f + 1 : NL; end
                c = 0;
            end
            m_taps = '0;
            m_taps[DW-1:0] = d;
            for (int k = 1; k <= NL; k++)
                if (k <= f) m_taps[k*DW +: DW] = hist[k-1][c];
            for (int k = NL-1; k >= 1; k--) hist[k][c] = hist[k-1][c];
            hist[0][c] = d;
            if (c == LW-1) begin m_col = 0; f = (f < NL) ? f + 1 : NL; end
            else m_col = c + 1;
            m_fill = f; m_full = (f == NL); m_valid = 1; m_colout = AB'(c);
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check(input string name, input logic ev, input logic [TW-1:0] et,
                         input logic [AB-1:0] ec, input logic ef, input logic ee);
        total++;
        if ({out_valid, out_taps, out_col, out_full, err_short_line} !== {ev, et, ec, ef, ee}) begin
            bad++;
            $display("FAIL %s: got v=%0b taps=%h col=%0d full=%0b err=%0b, want v=%0b taps=%h col=%0d full=%0b err=%0b",
                     name, out_valid, out_taps, out_col, out_full, err_short_line, ev, et, ec, ef, ee);
        end
    endtask

    // Drive one cycle, advance the model, and compare the DUT against it after the edge.
    task automatic step(input logic r, v, s, l, input logic [DW-1:0] d);
        rst = r; in_valid = v; in_sof = s; in_sol = l; in_data = d;
        model_step(r, v, s, l, d);
        @(posedge clk);
        #1;
        check("model", m_valid, m_taps, m_colout, m_full, m_err);
    endtask

    function automatic logic [TW-1:0] tp(input logic [DW-1:0] t2, t1, t0);
        return {t2, t1, t0};
    endfunction

    typedef struct {
        logic          v, s, l;
        logic [DW-1:0] d;
        logic          ev;
        logic [TW-1:0] et;
        logic [AB-1:0] ec;
        logic          ef, ee;
    } vec_t;

    // Pixel i (1-based) of a sof-started stream of consecutive values 1..12.
    function automatic vec_t pixrow(input int i);
        vec_t r;
        int   ln;
        ln   = (i - 1) / LW;
        r.v  = 1; r.s = (i == 1); r.l = 0; r.d = 8'(i);
        r.ev = 1;
        r.et = tp((ln >= 2) ? 8'(i - 8) : 8'h00, (ln >= 1) ? 8'(i - 4) : 8'h00, 8'(i));
        r.ec = AB'((i - 1) % LW);
        r.ef = (i >= 8);
        r.ee = 0;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t r;
        for (int k = 0; k < NL; k++)
            for (int c = 0; c < LW; c++) hist[k][c] = '0;
        rst = 1; in_valid = 0; in_sof = 0; in_sol = 0; in_data = '0;

        // Contiguous stream, then the same stream with idle cycles carrying stray framing bits.
        for (int i = 1; i <= 12; i++) tbl.push_back(pixrow(i));
        for (int i = 1; i <= 12; i++) begin
            r = pixrow(i);
            tbl.push_back(r);
            r.v = 0; r.s = (i % 3 == 0); r.l = (i % 2 == 0); r.d = 8'hAA; r.ev = 0;
            tbl.push_back(r);
        end

        step(1, 1, 1, 1, 8'h77);
        step(1, 0, 0, 0, 8'h00);
        check("reset", 0, '0, '0, 0, 0);

        foreach (tbl[n]) begin
            step(0, tbl[n].v, tbl[n].s, tbl[n].l, tbl[n].d);
            check($sformatf("vec%0d", n), tbl[n].ev, tbl[n].et, tbl[n].ec, tbl[n].ef, tbl[n].ee);
        end

        // Short line: sol lands on the third pixel of the second line.
        step(0, 1, 1, 0, 8'h10);
        step(0, 1, 0, 0, 8'h11);
        step(0, 1, 0, 0, 8'h12);
        step(0, 1, 0, 0, 8'h13);
        step(0, 1, 0, 0, 8'h20);
        step(0, 1, 0, 0, 8'h21);
        step(0, 1, 0, 1, 8'h30);
        check("short_sol", 1, tp(8'h10, 8'h20, 8'h30), 2'd0, 1, 1);
        step(0, 1, 0, 0, 8'h31);
        check("short_next", 1, tp(8'h11, 8'h21, 8'h31), 2'd1, 1, 1);
        step(0, 1, 0, 0, 8'h32);
        step(0, 1, 0, 0, 8'h33);

        // Mid-frame sof clears fill and the error; refill needs two full lines.
        step(0, 1, 1, 0, 8'h40);
        check("mid_sof", 1, tp(8'h00, 8'h00, 8'h40), 2'd0, 0, 0);
        for (int j = 1; j <= 7; j++) begin
            step(0, 1, 0, 0, 8'(8'h40 + j));
            if (j == 6) check("refill_7", 1, tp(8'h00, 8'h42, 8'h46), 2'd2, 0, 0);
            if (j == 7) check("refill_8", 1, tp(8'h00, 8'h43, 8'h47), 2'd3, 1, 0);
        end

        // Reset mid-line at column 2 while full.
        step(0, 1, 0, 0, 8'h48);
        step(0, 1, 0, 0, 8'h49);
        step(1, 1, 0, 0, 8'h4A);
        check("rst_out", 0, '0, '0, 0, 0);
        step(0, 1, 0, 0, 8'h53);
        check("rst_first", 1, tp(8'h00, 8'h00, 8'h53), 2'd0, 0, 0);

        // Overlong line wraps without error.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, (i == 0), 0, 8'(8'h60 + i));
            check($sformatf("overlong%0d", i), 1,
                  tp(8'h00, (i >= 4) ? 8'(8'h60 + i - 4) : 8'h00, 8'(8'h60 + i)),
                  AB'(i % LW), 0, 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic rr, vv, ss, ll;
            rr = ($urandom_range(0, 199) == 0);
            vv = ($urandom_range(0, 3) != 0);
            ss = ($urandom_range(0, 49) == 0);
            ll = (m_col == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            step(rr, vv, ss, ll, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
